// File: rtl/pdm_duty_meter.sv
// Multi-channel PDM duty-cycle meter: counts ones per channel over a 2^WIN_LOG2 window
// and publishes a scaled duty word with a done strobe. Optional peak hold: PDM_DUTY_PEAK_EN.
module pdm_duty_meter #(
    parameter int NUM_CH   = 2,
    parameter int WIN_LOG2 = 16,
    parameter int DUTY_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_CH-1:0]          PDM,
    output logic [NUM_CH*DUTY_W-1:0]   duty,
    output logic                       done,
    output logic                       busy,
    input  logic                       peak_clr,
    output logic [NUM_CH*DUTY_W-1:0]   peak
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

    localparam int SHL  = (DUTY_W > WIN_LOG2) ? (DUTY_W - WIN_LOG2) : 0;
    localparam int SHR  = (WIN_LOG2 > DUTY_W) ? (WIN_LOG2 - DUTY_W) : 0;
    localparam int WIDE = WIN_LOG2 + DUTY_W;

    // A full window of ones (count == 2^WIN_LOG2) is the only value with the top bit set.
    function automatic logic [DUTY_W-1:0] scale_duty(input logic [WIN_LOG2:0] cnt);
        logic [WIDE-1:0]   wide;
        logic [DUTY_W-1:0] res;
        wide = {{DUTY_W{1'b0}}, cnt[WIN_LOG2-1:0]};
        wide = (wide << SHL) >> SHR;
        if (cnt[WIN_LOG2]) begin
            res = {DUTY_W{1'b1}};
        end else begin
            res = wide[DUTY_W-1:0];
        end
        return res;
    endfunction

    state_t                     state_r;
    logic [WIN_LOG2-1:0]        wcnt_r;
    logic                       busy_r;
    logic                       upd_r;
    logic                       done_r;
    logic [NUM_CH*DUTY_W-1:0]   duty_r;
    logic [WIN_LOG2:0]          acc_r [NUM_CH];
    logic [WIN_LOG2:0]          fin_r [NUM_CH];
    logic [WIN_LOG2:0]          sum_s [NUM_CH];
    logic [DUTY_W-1:0]          duty_new_s [NUM_CH];
    logic                       last_s;

    assign last_s = &wcnt_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign sum_s[g]      = acc_r[g] + {{WIN_LOG2{1'b0}}, PDM[g]};
        assign duty_new_s[g] = scale_duty(fin_r[g]);
    end

    // Control FSM: window counter, busy flag and end-of-window update request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            wcnt_r  <= {WIN_LOG2{1'b0}};
            busy_r  <= 1'b0;
            upd_r   <= 1'b0;
        end else begin
            upd_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wcnt_r <= {WIN_LOG2{1'b0}};
                    if (en) begin
                        state_r <= ST_PRIME;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    if (!en) begin
                        state_r <= ST_IDLE;
                        wcnt_r  <= {WIN_LOG2{1'b0}};
                        busy_r  <= 1'b0;
                    end else begin
                        wcnt_r  <= wcnt_r + WIN_LOG2'(1);
                        busy_r  <= 1'b1;
                        if (last_s) begin
                            state_r <= ST_ACCUM;
                        end else begin
                            state_r <= ST_PRIME;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (last_s) begin
                        // The final sample always completes the window, even if en just dropped.
                        upd_r <= 1'b1;
                        if (en) begin
                            state_r <= ST_ACCUM;
                            wcnt_r  <= wcnt_r + WIN_LOG2'(1);
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            wcnt_r  <= {WIN_LOG2{1'b0}};
                            busy_r  <= 1'b0;
                        end
                    end else if (!en) begin
                        state_r <= ST_IDLE;
                        wcnt_r  <= {WIN_LOG2{1'b0}};
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_ACCUM;
                        wcnt_r  <= wcnt_r + WIN_LOG2'(1);
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wcnt_r  <= {WIN_LOG2{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel accumulators; the completed window count is parked in fin_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_r[i] <= {(WIN_LOG2+1){1'b0}};
                fin_r[i] <= {(WIN_LOG2+1){1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state_r == ST_ACCUM) && en && !last_s) begin
                    acc_r[i] <= sum_s[i];
                end else begin
                    acc_r[i] <= {(WIN_LOG2+1){1'b0}};
                end
                if ((state_r == ST_ACCUM) && last_s) begin
                    fin_r[i] <= sum_s[i];
                end else begin
                    fin_r[i] <= fin_r[i];
                end
            end
        end
    end

    // Duty words and done strobe change together on the update edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= {(NUM_CH*DUTY_W){1'b0}};
            done_r <= 1'b0;
        end else begin
            done_r <= upd_r;
            if (upd_r) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    duty_r[i*DUTY_W +: DUTY_W] <= duty_new_s[i];
                end
            end else begin
                duty_r <= duty_r;
            end
        end
    end

    assign duty = duty_r;
    assign done = done_r;
    assign busy = busy_r;

`ifdef PDM_DUTY_PEAK_EN
    logic [NUM_CH*DUTY_W-1:0] peak_r;
    logic [NUM_CH*DUTY_W-1:0] peak_nxt_s;
    logic [DUTY_W-1:0]        peak_base_s [NUM_CH];

    // Next peak value: clear first, then take the max against a fresh duty word.
    always_comb begin
        peak_nxt_s = peak_r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (peak_clr) begin
                peak_base_s[i] = {DUTY_W{1'b0}};
            end else begin
                peak_base_s[i] = peak_r[i*DUTY_W +: DUTY_W];
            end
            if (upd_r && (duty_new_s[i] > peak_base_s[i])) begin
                peak_nxt_s[i*DUTY_W +: DUTY_W] = duty_new_s[i];
            end else begin
                peak_nxt_s[i*DUTY_W +: DUTY_W] = peak_base_s[i];
            end
        end
    end

    // Peak registers survive en and aborts; only reset or peak_clr clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_r <= {(NUM_CH*DUTY_W){1'b0}};
        end else begin
            peak_r <= peak_nxt_s;
        end
    end

    assign peak = peak_r;
`else
    logic unused_peak_clr_s;
    assign unused_peak_clr_s = peak_clr;
    assign peak = {(NUM_CH*DUTY_W){1'b0}};
`endif

endmodule
